// File: rtl/arc4_pkg.sv
// ============================================================================
// Module      : arc4_pkg
// Description : Types, constants and helpers shared by the ARC4 datapath
//               stages (byte type, PRGA state encoding, printable-ASCII
//               range check used by the optional plaintext checker).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arc4_pkg;

    typedef logic [7:0] byte_t;

    // PRGA controller states; one WAIT state always separates a memory read
    // from the cycle in which its data is consumed.
    typedef enum logic [3:0] {
        PRGA_IDLE    = 4'd0,
        PRGA_RDLEN   = 4'd1,
        PRGA_WAITLEN = 4'd2,
        PRGA_WRLEN   = 4'd3,
        PRGA_RDI     = 4'd4,
        PRGA_WAITI   = 4'd5,
        PRGA_RDJ     = 4'd6,
        PRGA_WAITJ   = 4'd7,
        PRGA_WRI     = 4'd8,
        PRGA_WRJ     = 4'd9,
        PRGA_RDK     = 4'd10,
        PRGA_WAITK   = 4'd11,
        PRGA_WRPT    = 4'd12
    } prga_state_t;

    localparam byte_t ASCII_LO = 8'h20;
    localparam byte_t ASCII_HI = 8'h7E;

    function automatic logic is_printable(input byte_t b);
        return (b >= ASCII_LO) && (b <= ASCII_HI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prga_if.sv
// ============================================================================
// Module      : prga_if
// Description : Handshake and memory-port bundle of the PRGA stage.
//               slave  : PRGA side (drives addresses, write data, rdy, valid)
//               master : controller/memory side (drives en and read data)
// Ports       : en, rdy, s_addr, s_rddata, s_wrdata, s_wren, ct_addr,
//               ct_rddata, pt_addr, pt_wrdata, pt_wren, valid
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prga_if;
    import arc4_pkg::*;

    logic  en;
    logic  rdy;
    byte_t s_addr;
    byte_t s_rddata;
    byte_t s_wrdata;
    logic  s_wren;
    byte_t ct_addr;
    byte_t ct_rddata;
    byte_t pt_addr;
    byte_t pt_wrdata;
    logic  pt_wren;
    logic  valid;

    modport slave (
        input  en, s_rddata, ct_rddata,
        output rdy, s_addr, s_wrdata, s_wren, ct_addr,
               pt_addr, pt_wrdata, pt_wren, valid
    );

    modport master (
        output en, s_rddata, ct_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, ct_addr,
               pt_addr, pt_wrdata, pt_wren, valid
    );

endinterface

`default_nettype wire

// File: rtl/prga.sv
// ============================================================================
// Module      : prga
// Description : ARC4 pseudo-random generation stage. Reads the length-
//               prefixed ciphertext, updates the S permutation and writes
//               the length-prefixed plaintext. Memories have registered
//               addresses; every read is followed by a WAIT state.
// Ports       : clk, rst_n (async, active low), bus (prga_if.slave)
// Parameters  : MAX_LEN - longest message accepted; longer lengths clamp.
// Options     : PRGA_ASCII_CHECK_EN - when defined, valid drops to 0 once a
//               plaintext data byte outside 0x20..0x7E is written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prga
    import arc4_pkg::*;
#(
    parameter int MAX_LEN = 255
) (
    input  logic   clk,
    input  logic   rst_n,
    prga_if.slave  bus
);

    localparam byte_t LEN_CAP = byte_t'(MAX_LEN);

    prga_state_t state_q;
    logic        rdy_q;
    byte_t       i_q, j_q, k_q, si_q, sj_q, len_q;
    byte_t       s_addr_q, s_wrdata_q, ct_addr_q, pt_addr_q, pt_wrdata_q;
    logic        s_wren_q, pt_wren_q;

    byte_t len_d;
    byte_t j_d;
    byte_t k_d;
    byte_t pt_d;

    assign len_d = (bus.ct_rddata > LEN_CAP) ? LEN_CAP : bus.ct_rddata;
    assign j_d   = j_q + bus.s_rddata;
    assign k_d   = k_q + 8'd1;
    assign pt_d  = bus.s_rddata ^ bus.ct_rddata;

`ifdef PRGA_ASCII_CHECK_EN
    logic valid_q;
    assign bus.valid = valid_q;
`else
    assign bus.valid = 1'b1;
`endif

    assign bus.rdy       = rdy_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wrdata  = s_wrdata_q;
    assign bus.s_wren    = s_wren_q;
    assign bus.ct_addr   = ct_addr_q;
    assign bus.pt_addr   = pt_addr_q;
    assign bus.pt_wrdata = pt_wrdata_q;
    assign bus.pt_wren   = pt_wren_q;

    // Outputs are registered: the values belonging to a state are loaded on
    // the edge that enters it, so each state "drives" its own address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PRGA_IDLE;
            rdy_q       <= 1'b1;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            len_q       <= '0;
            s_addr_q    <= '0;
            s_wrdata_q  <= '0;
            s_wren_q    <= 1'b0;
            ct_addr_q   <= '0;
            pt_addr_q   <= '0;
            pt_wrdata_q <= '0;
            pt_wren_q   <= 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
            valid_q     <= 1'b1;
`endif
        end else begin
            s_wren_q  <= 1'b0;
            pt_wren_q <= 1'b0;
            unique case (state_q)
                PRGA_IDLE: begin
                    if (bus.en) begin
                        state_q   <= PRGA_RDLEN;
                        rdy_q     <= 1'b0;
                        i_q       <= '0;
                        j_q       <= '0;
                        k_q       <= '0;
                        ct_addr_q <= '0;
`ifdef PRGA_ASCII_CHECK_EN
                        // Accept re-arms the flag; only this run's bytes count.
                        valid_q   <= 1'b1;
`endif
                    end
                end
                PRGA_RDLEN:   state_q <= PRGA_WAITLEN;
                PRGA_WAITLEN: begin
                    len_q       <= len_d;
                    pt_addr_q   <= '0;
                    pt_wrdata_q <= len_d;
                    pt_wren_q   <= 1'b1;
                    state_q     <= PRGA_WRLEN;
                end
                PRGA_WRLEN: begin
                    if (len_q == '0) begin
                        rdy_q   <= 1'b1;
                        state_q <= PRGA_IDLE;
                    end else begin
                        i_q      <= 8'd1;
                        k_q      <= 8'd1;
                        s_addr_q <= 8'd1;
                        state_q  <= PRGA_RDI;
                    end
                end
                PRGA_RDI:     state_q <= PRGA_WAITI;
                PRGA_WAITI: begin
                    si_q     <= bus.s_rddata;
                    j_q      <= j_d;
                    s_addr_q <= j_d;
                    state_q  <= PRGA_RDJ;
                end
                PRGA_RDJ:     state_q <= PRGA_WAITJ;
                PRGA_WAITJ: begin
                    sj_q       <= bus.s_rddata;
                    s_addr_q   <= i_q;
                    s_wrdata_q <= bus.s_rddata;
                    s_wren_q   <= 1'b1;
                    state_q    <= PRGA_WRI;
                end
                PRGA_WRI: begin
                    s_addr_q   <= j_q;
                    s_wrdata_q <= si_q;
                    s_wren_q   <= 1'b1;
                    state_q    <= PRGA_WRJ;
                end
                PRGA_WRJ: begin
                    // Sum is order-independent, so pre-swap values suffice.
                    s_addr_q  <= si_q + sj_q;
                    ct_addr_q <= k_q;
                    state_q   <= PRGA_RDK;
                end
                PRGA_RDK:     state_q <= PRGA_WAITK;
                PRGA_WAITK: begin
                    pt_addr_q   <= k_q;
                    pt_wrdata_q <= pt_d;
                    pt_wren_q   <= 1'b1;
`ifdef PRGA_ASCII_CHECK_EN
                    if (!is_printable(pt_d)) begin
                        valid_q <= 1'b0;
                    end
`endif
                    state_q     <= PRGA_WRPT;
                end
                PRGA_WRPT: begin
                    if (k_q == len_q) begin
                        rdy_q   <= 1'b1;
                        state_q <= PRGA_IDLE;
                    end else begin
                        i_q      <= k_d;
                        k_q      <= k_d;
                        s_addr_q <= k_d;
                        state_q  <= PRGA_RDI;
                    end
                end
                default: begin
                    rdy_q   <= 1'b1;
                    state_q <= PRGA_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prga.sv
// ============================================================================
// Module      : tb_prga
// Description : Scoreboard bench for prga. Expected plaintext writes are
//               queued from a reference ARC4 PRGA model; a monitor pops and
//               compares on every pt write. Also checks latency, final S,
//               S write count, valid and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prga;
    import arc4_pkg::*;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prga_if bus ();

    prga #(.MAX_LEN(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memories with registered read address
    byte_t s_mem [256];
    byte_t ct_mem[256];
    byte_t s_init[256];
    byte_t ct_init[256];
    byte_t exp_s [256];
    logic  load = 1'b0;
    byte_t s_addr_r, ct_addr_r;

    always @(posedge clk) begin
        s_addr_r  <= bus.s_addr;
        ct_addr_r <= bus.ct_addr;
        if (load) begin
            for (int n = 0; n < 256; n++) begin
                s_mem[n]  <= s_init[n];
                ct_mem[n] <= ct_init[n];
            end
        end else if (bus.s_wren) begin
            s_mem[bus.s_addr] <= bus.s_wrdata;
        end
    end

    assign bus.s_rddata  = s_mem[s_addr_r];
    assign bus.ct_rddata = ct_mem[ct_addr_r];

    int   n_chk = 0;
    int   n_pass = 0;
    int   s_wr_cnt = 0;
    int   exp_swr = 0;
    logic exp_valid = 1'b1;
    wr_t  exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes plaintext
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst_n && bus.s_wren) s_wr_cnt++;
        if (rst_n && bus.pt_wren) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL pt_unexpected_write: addr=0x%0h data=0x%0h, no write expected",
                         bus.pt_addr, bus.pt_wrdata);
            end else begin
                e = exp_q.pop_front();
                chk("pt_addr", int'(bus.pt_addr), int'(e.a));
                chk("pt_data", int'(bus.pt_wrdata), int'(e.d));
            end
        end
    end

    function automatic logic printable(input byte_t b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

    task automatic ident_s();
        for (int n = 0; n < 256; n++) s_init[n] = byte_t'(n);
    endtask

    task automatic rand_perm();
        byte_t t;
        int r;
        ident_s();
        for (int n = 255; n > 0; n--) begin
            r = $urandom_range(0, n);
            t = s_init[n]; s_init[n] = s_init[r]; s_init[r] = t;
        end
    endtask

    task automatic rand_ct(input int L);
        ct_init[0] = byte_t'(L);
        for (int n = 1; n < 256; n++) ct_init[n] = byte_t'($urandom_range(0, 255));
    endtask

    // Reference: textbook ARC4 PRGA over an array copy of S
    task automatic model(input int L);
        byte_t sm[256];
        byte_t t, d;
        int i, j;
        for (int n = 0; n < 256; n++) sm[n] = s_init[n];
        exp_q.delete();
        exp_q.push_back(wr_t'({8'd0, byte_t'(L)}));
        exp_valid = 1'b1;
        j = 0;
        for (int k = 1; k <= L; k++) begin
            i = k % 256;
            j = (j + int'(sm[i])) % 256;
            t = sm[i]; sm[i] = sm[j]; sm[j] = t;
            d = sm[(int'(sm[i]) + int'(sm[j])) % 256] ^ ct_init[k];
            exp_q.push_back(wr_t'({byte_t'(k), d}));
`ifdef PRGA_ASCII_CHECK_EN
            if (!printable(d)) exp_valid = 1'b0;
`endif
        end
        for (int n = 0; n < 256; n++) exp_s[n] = sm[n];
        exp_swr = 2 * L;
    endtask

    task automatic load_mem();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic check_s(input string name);
        int bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) bad++;
        chk(name, bad, 0);
    endtask

    // Runs one message; expectations must already be set up by the caller.
    task automatic execute(input int L, input bit en_mid);
        int cyc = 0;
        load_mem();
        s_wr_cnt = 0;
        chk("rdy_before_start", int'(bus.rdy), 1);
        bus.en = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (!bus.rdy && en_mid) bus.en = 1'($urandom_range(0, 1));
            else bus.en = 1'b0;
        end while (!bus.rdy && cyc < 3000);
        chk("rdy_latency", cyc, 4 + 9 * L);
        chk("pt_writes_outstanding", exp_q.size(), 0);
        check_s("s_final_mismatches");
        chk("s_write_count", s_wr_cnt, exp_swr);
        chk("valid", int'(bus.valid), int'(exp_valid));
    endtask

    initial begin
        int L;
        bus.en = 1'b0;
        for (int n = 0; n < 256; n++) begin
            s_init[n]  = '0;
            ct_init[n] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdy", int'(bus.rdy), 1);
        chk("rst_valid", int'(bus.valid), 1);
        chk("rst_s_wren", int'(bus.s_wren), 0);
        chk("rst_pt_wren", int'(bus.pt_wren), 0);
        chk("rst_s_addr", int'(bus.s_addr), 0);
        chk("rst_ct_addr", int'(bus.ct_addr), 0);
        chk("rst_pt_addr", int'(bus.pt_addr), 0);
        chk("rst_s_wrdata", int'(bus.s_wrdata), 0);
        chk("rst_pt_wrdata", int'(bus.pt_wrdata), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity S, ct={1,0x00} -> pt={1,0x02}, S unchanged
        ident_s(); ct_init[0] = 8'd1; ct_init[1] = 8'h00;
        exp_q.delete();
        exp_q.push_back(wr_t'({8'd0, 8'd1}));
        exp_q.push_back(wr_t'({8'd1, 8'h02}));
        for (int n = 0; n < 256; n++) exp_s[n] = byte_t'(n);
        exp_swr = 2;
`ifdef PRGA_ASCII_CHECK_EN
        exp_valid = 1'b0;
`else
        exp_valid = 1'b1;
`endif
        execute(1, 1'b0);

        // Identity S, ct={2,0x00,0x41} -> pt={2,0x02,0x44}, S[2]/S[3] swapped
        ident_s(); ct_init[0] = 8'd2; ct_init[1] = 8'h00; ct_init[2] = 8'h41;
        exp_q.delete();
        exp_q.push_back(wr_t'({8'd0, 8'd2}));
        exp_q.push_back(wr_t'({8'd1, 8'h02}));
        exp_q.push_back(wr_t'({8'd2, 8'h44}));
        for (int n = 0; n < 256; n++) exp_s[n] = byte_t'(n);
        exp_s[2] = 8'd3; exp_s[3] = 8'd2;
        exp_swr = 4;
`ifdef PRGA_ASCII_CHECK_EN
        exp_valid = 1'b0;
`else
        exp_valid = 1'b1;
`endif
        execute(2, 1'b0);

        // Identity S, ct={1,0x43} -> pt[1]=0x41 (printable)
        ident_s(); ct_init[0] = 8'd1; ct_init[1] = 8'h43;
        exp_q.delete();
        exp_q.push_back(wr_t'({8'd0, 8'd1}));
        exp_q.push_back(wr_t'({8'd1, 8'h41}));
        for (int n = 0; n < 256; n++) exp_s[n] = byte_t'(n);
        exp_swr = 2;
        exp_valid = 1'b1;
        execute(1, 1'b0);

        // Zero length: only pt[0]=0, no S writes, 4-cycle latency
        rand_perm(); rand_ct(0);
        model(0);
        execute(0, 1'b0);

        // en pulsed while busy must be ignored
        rand_perm(); rand_ct(6);
        model(6);
        execute(6, 1'b1);

        // Reset asserted during WRI of byte 1
        rand_perm(); rand_ct(3);
        model(3);
        load_mem();
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (7) @(negedge clk);
        chk("wri_s_wren", int'(bus.s_wren), 1);
        chk("wri_s_addr", int'(bus.s_addr), 1);
        chk("pt_len_written_before_reset", exp_q.size(), 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", int'(bus.rdy), 1);
        chk("midrst_s_wren", int'(bus.s_wren), 0);
        chk("midrst_pt_wren", int'(bus.pt_wren), 0);
        exp_q.delete();
        for (int n = 0; n < 256; n++) exp_s[n] = s_init[n];
        @(negedge clk);
        check_s("midrst_s_untouched");
        rst_n = 1'b1;
        @(negedge clk);
        model(3);
        execute(3, 1'b0);

        // Randomized messages
        for (int r = 0; r < 25; r++) begin
            L = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 20);
            rand_perm(); rand_ct(L);
            model(L);
            execute(L, r[0]);
        end

        // Longest message
        rand_perm(); rand_ct(255);
        model(255);
        execute(255, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
